// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types, constants and round-robin winner function for mem_req_arbiter
package mem_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_e;

    localparam int DEFAULT_TIMEOUT = 16;
    localparam int MAX_REQ         = 8;

    // First set bit at or after ptr, wrapping modulo n; 0 when nothing is requesting.
    function automatic int rr_winner(input logic [MAX_REQ-1:0] req, input int ptr, input int n);
        int   win;
        int   idx;
        logic found;
        win   = 0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = (ptr + i) % n;
            if (!found && (i < n) && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: request vector and pointer in, winner index out
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   winner_o,
    output logic               any_req_o
);

    logic [MAX_REQ-1:0] req_pad;

    always_comb begin
        req_pad                = '0;
        req_pad[NUM_REQ-1:0]   = req_i;
        winner_o               = IDX_W'(rr_winner(req_pad, int'(ptr_i), NUM_REQ));
        any_req_o              = |req_i;
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - shares one memory port among NUM_REQ requesters with round-robin grants
// and a wait-timeout watchdog that aborts hung accesses.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_wr_rd_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*WIDTH-1:0]      req_wdata_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [NUM_REQ-1:0]            req_err_o,
    output logic [WIDTH-1:0]              req_rdata_o,
    output logic                          valid_o,
    output logic                          wr_rd_o,
    output logic [ADDR_WIDTH-1:0]         addr_o,
    output logic [WIDTH-1:0]              wdata_o,
    input  logic                          ready_i,
    input  logic [WIDTH-1:0]              rdata_i,
    output logic                          busy_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT) + 1;

    arb_state_e            state_q,  state_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]      grant_q,  grant_d;
    logic [TMR_W-1:0]      timer_q,  timer_d;
    logic                  valid_q,  valid_d;
    logic                  wr_rd_q,  wr_rd_d;
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic [WIDTH-1:0]      wdata_q,  wdata_d;

    logic [IDX_W-1:0]      winner;
    logic                  any_req;
    logic [IDX_W-1:0]      next_ptr;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .req_i     (req_valid_i),
        .ptr_i     (rr_ptr_q),
        .winner_o  (winner),
        .any_req_o (any_req)
    );

    assign next_ptr = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        timer_d     = timer_q;
        valid_d     = valid_q;
        wr_rd_d     = wr_rd_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        req_ready_o = '0;
        req_err_o   = '0;
        req_rdata_o = '0;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                wr_rd_d = 1'b0;
                addr_d  = '0;
                wdata_d = '0;
                if (any_req) begin
                    state_d = ISSUE;
                    valid_d = 1'b1;
                    wr_rd_d = req_wr_rd_i[winner];
                    addr_d  = req_addr_i[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d = req_wdata_i[int'(winner)*WIDTH +: WIDTH];
                    grant_d = winner;
                    timer_d = '0;
                end
            end
            ISSUE: begin
                // Completion and abort both release the bus and move the pointer past the owner.
                if (ready_i || (timer_q == TMR_W'(TIMEOUT - 1))) begin
                    if (ready_i) begin
                        req_ready_o[grant_q] = 1'b1;
                        req_rdata_o          = rdata_i;
                    end else begin
                        req_err_o[grant_q]   = 1'b1;
                    end
                    state_d  = IDLE;
                    valid_d  = 1'b0;
                    wr_rd_d  = 1'b0;
                    addr_d   = '0;
                    wdata_d  = '0;
                    rr_ptr_d = next_ptr;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            timer_q  <= '0;
            valid_q  <= 1'b0;
            wr_rd_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            timer_q  <= timer_d;
            valid_q  <= valid_d;
            wr_rd_q  <= wr_rd_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign valid_o = valid_q;
    assign wr_rd_o = wr_rd_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;
    assign busy_o  = (state_q == ISSUE);

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - directed self-checking bench for mem_req_arbiter
module tb_mem_req_arbiter;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [3:0]   req_valid_i;
    logic [3:0]   req_wr_rd_i;
    logic [31:0]  req_addr_i;
    logic [127:0] req_wdata_i;
    logic [3:0]   req_ready_o;
    logic [3:0]   req_err_o;
    logic [31:0]  req_rdata_o;
    logic         valid_o;
    logic         wr_rd_o;
    logic [7:0]   addr_o;
    logic [31:0]  wdata_o;
    logic         ready_i;
    logic [31:0]  rdata_i;
    logic         busy_o;

    int checks = 0;
    int errors = 0;
    int rdy_cnt[4];
    int err_cnt[4];
    int rdy_total;
    int err_total;

    always #5 clk_i = ~clk_i;

    mem_req_arbiter #(.NUM_REQ(4), .WIDTH(32), .ADDR_WIDTH(8), .TIMEOUT(16)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_wr_rd_i (req_wr_rd_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_ready_o (req_ready_o),
        .req_err_o   (req_err_o),
        .req_rdata_o (req_rdata_o),
        .valid_o     (valid_o),
        .wr_rd_o     (wr_rd_o),
        .addr_o      (addr_o),
        .wdata_o     (wdata_o),
        .ready_i     (ready_i),
        .rdata_i     (rdata_i),
        .busy_o      (busy_o)
    );

    // Pulse counters sampled mid-cycle, after the bench has driven this cycle's inputs.
    initial begin
        for (int k = 0; k < 4; k++) begin rdy_cnt[k] = 0; err_cnt[k] = 0; end
        forever begin
            @(negedge clk_i);
            #2;
            for (int k = 0; k < 4; k++) begin
                if (req_ready_o[k] === 1'b1) rdy_cnt[k]++;
                if (req_err_o[k] === 1'b1)   err_cnt[k]++;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic v, input logic wr, input logic [7:0] a, input logic [31:0] d);
        req_valid_i[k]          = v;
        req_wr_rd_i[k]          = wr;
        req_addr_i[k*8 +: 8]    = a;
        req_wdata_i[k*32 +: 32] = d;
    endtask

    task automatic cyc();
        @(negedge clk_i);
    endtask

    task automatic sum_pulses();
        rdy_total = rdy_cnt[0] + rdy_cnt[1] + rdy_cnt[2] + rdy_cnt[3];
        err_total = err_cnt[0] + err_cnt[1] + err_cnt[2] + err_cnt[3];
    endtask

    int grants[$];
    int times[$];
    int cnum;
    int r0;
    int e0;

    initial begin
        rst_i       = 1'b1;
        req_valid_i = '0;
        req_wr_rd_i = '0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        ready_i     = 1'b0;
        rdata_i     = '0;
        cyc(); cyc();
        rst_i = 1'b0;
        #1;
        check("rst_valid", valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_addr", addr_o, 0);
        check("rst_wdata", wdata_o, 0);
        check("rst_pulses", {req_ready_o, req_err_o}, 0);
        check("rst_ptr", dut.rr_ptr_q, 0);

        // Single write from req0, ready in third ISSUE cycle
        cyc(); set_req(0, 1, 1, 8'h10, 32'hDEADBEEF);
        for (int c = 1; c <= 3; c++) begin
            cyc(); ready_i = (c == 3); #1;
            check($sformatf("wr_valid_c%0d", c), valid_o, 1);
            check($sformatf("wr_addr_c%0d", c), addr_o, 8'h10);
            check($sformatf("wr_data_c%0d", c), wdata_o, 32'hDEADBEEF);
            check($sformatf("wr_ready_c%0d", c), req_ready_o, (c == 3) ? 4'b0001 : 4'b0000);
        end
        cyc(); ready_i = 0; set_req(0, 0, 0, 0, 0); #1;
        check("wr_after_busy", busy_o, 0);
        check("wr_after_valid", valid_o, 0);
        check("wr_pulse_count", rdy_cnt[0], 1);

        // Read from req2
        cyc(); set_req(2, 1, 0, 8'h3F, 0);
        cyc(); rdata_i = 32'hAAAA5555; #1;
        check("rd_addr", addr_o, 8'h3F);
        check("rd_wr", wr_rd_o, 0);
        check("rd_rdata_idle", req_rdata_o, 0);
        cyc(); ready_i = 1; rdata_i = 32'h12345678; #1;
        check("rd_ready", req_ready_o, 4'b0100);
        check("rd_rdata", req_rdata_o, 32'h12345678);
        cyc(); ready_i = 0; set_req(2, 0, 0, 0, 0); #1;
        check("rd_rdata_after", req_rdata_o, 0);
        check("rd_ptr", dut.rr_ptr_q, 3);

        // Fairness: all four requesting, zero-wait memory, starting from a fresh pointer
        rst_i = 1; cyc(); rst_i = 0;
        for (int k = 0; k < 4; k++) set_req(k, 1, 1, 8'(8'h40 + k), 32'(k));
        ready_i = 1;
        cnum = 0;
        while (grants.size() < 8 && cnum < 40) begin
            cyc(); #1; cnum++;
            for (int k = 0; k < 4; k++) if (req_ready_o[k]) begin grants.push_back(k); times.push_back(cnum); end
        end
        cyc(); req_valid_i = '0; ready_i = 0;
        check("fair_count", grants.size(), 8);
        for (int i = 0; i < grants.size(); i++) begin
            check($sformatf("fair_grant%0d", i), grants[i], i % 4);
            if (i > 0) check($sformatf("fair_gap%0d", i), times[i] - times[i-1], 2);
        end

        // Timeout on req1 read
        r0 = rdy_cnt[1]; e0 = err_cnt[1];
        cyc(); set_req(1, 1, 0, 8'h22, 0);
        for (int c = 1; c <= 16; c++) begin
            cyc(); #1;
            check($sformatf("to_err_c%0d", c), req_err_o, (c == 16) ? 4'b0010 : 4'b0000);
            if (c == 16) check("to_valid_c16", valid_o, 1);
        end
        cyc(); set_req(1, 0, 0, 0, 0); #1;
        check("to_valid_after", valid_o, 0);
        check("to_ptr", dut.rr_ptr_q, 2);
        check("to_no_ready", rdy_cnt[1] - r0, 0);
        check("to_err_count", err_cnt[1] - e0, 1);

        // Reset during the third ISSUE cycle
        sum_pulses(); r0 = rdy_total; e0 = err_total;
        cyc(); set_req(0, 1, 1, 8'h55, 32'h55555555);
        cyc(); cyc(); #1;
        check("mr_busy", busy_o, 1);
        cyc(); rst_i = 1; #1;
        check("mr_no_pulse", {req_ready_o, req_err_o}, 0);
        cyc(); rst_i = 0; set_req(0, 0, 0, 0, 0); #1;
        check("mr_valid", valid_o, 0);
        check("mr_addr", addr_o, 0);
        check("mr_wdata", wdata_o, 0);
        check("mr_busy_after", busy_o, 0);
        check("mr_ptr", dut.rr_ptr_q, 0);
        sum_pulses();
        check("mr_pulses", (rdy_total - r0) + (err_total - e0), 0);
        cyc(); set_req(3, 1, 0, 8'h77, 0);
        cyc(); ready_i = 1; rdata_i = 32'hCAFEF00D; #1;
        check("mr_r3_addr", addr_o, 8'h77);
        check("mr_r3_ready", req_ready_o, 4'b1000);
        check("mr_r3_rdata", req_rdata_o, 32'hCAFEF00D);
        cyc(); ready_i = 0; set_req(3, 0, 0, 0, 0);

        // Early drop of req0 after grant
        set_req(0, 1, 1, 8'h21, 32'h0BADF00D);
        cyc(); set_req(0, 0, 1, 8'hEE, 32'h0); #1;
        check("ed_addr_c1", addr_o, 8'h21);
        cyc(); ready_i = 1; #1;
        check("ed_addr_c2", addr_o, 8'h21);
        check("ed_wdata_c2", wdata_o, 32'h0BADF00D);
        check("ed_ready", req_ready_o, 4'b0001);

        // ready_i while idle is ignored
        cyc(); #1;
        check("idle_ready_busy", busy_o, 0);
        check("idle_ready_pulse", req_ready_o, 0);
        cyc(); ready_i = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares the single memory port (valid_i/wr_rd_i/addr_i/wdata_i out, ready_o/rdata_o in) between NUM_REQ requesters.
- Each requester has its own valid/ready port.
- Grants are round-robin; the winning request is latched and held stable on the memory bus until ready_o.
- A wait-timeout watchdog aborts hung transactions and reports an error to the owning requester.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, `WIDTH, data width.
- ADDR_WIDTH, `ADDR_WIDTH, address width.
- TIMEOUT, 16, maximum ISSUE cycles without ready_o before abort (>=2).

Ports:
- clk_i  in  1  clock; all logic on posedge.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  NUM_REQ  per-requester request.
- req_wr_rd_i  in  NUM_REQ  1=write, 0=read.
- req_addr_i  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester k at slice k.
- req_wdata_i  in  NUM_REQ*WIDTH  packed write data.
- req_ready_o  out  NUM_REQ  one-cycle completion pulse to the owner.
- req_err_o  out  NUM_REQ  one-cycle timeout pulse to the owner.
- req_rdata_o  out  WIDTH  read data; valid when req_ready_o[k] is high and the access was a read.
- valid_o  out  1  to memory valid_i.
- wr_rd_o  out  1  to memory wr_rd_i.
- addr_o  out  ADDR_WIDTH  to memory addr_i.
- wdata_o  out  WIDTH  to memory wdata_i.
- ready_i  in  1  from memory ready_o.
- rdata_i  in  WIDTH  from memory rdata_o.
- busy_o  out  1  high while in ISSUE.

Behaviour:
- Reset (rst_i high at posedge):
  - state=IDLE, rr_ptr=0, grant=0, timer=0.
  - valid_o, wr_rd_o, addr_o, wdata_o, busy_o = 0.
  - req_ready_o, req_err_o = 0.
- Reset wins over all other events. An in-flight transaction is dropped with no ready/err pulse, and valid_o is 0 the following cycle.
- FSM IDLE:
  - If any req_valid_i is set, select the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Register into valid_o/wr_rd_o/addr_o/wdata_o: valid_o=1 plus the winner's wr_rd/addr/wdata. Set grant=winner, timer=0, go to ISSUE.
  - No request: stay in IDLE, outputs 0.
- FSM ISSUE:
  - Memory outputs are held constant; later requester input changes are ignored.
  - ready_i=1: combinational req_ready_o[grant]=1, req_rdata_o=rdata_i. Next edge: valid_o=0, rr_ptr=(grant+1) mod NUM_REQ, go to IDLE.
  - ready_i=0 and timer==TIMEOUT-1: combinational req_err_o[grant]=1. Next edge: valid_o=0, rr_ptr advances, go to IDLE.
  - Otherwise timer++.
- req_rdata_o is 0 whenever no req_ready_o bit is set.
- Latency: request seen in IDLE at edge T gives valid_o high from T+1. With zero-wait memory (ready_i in first ISSUE cycle), req_ready_o pulses in cycle T+1. IDLE is re-entered at T+2.
- Minimum of one IDLE cycle between transactions; peak throughput is one access per 2 cycles.
- Requester rule: hold req_valid_i and fields until req_ready_o or req_err_o.
  - Dropping req_valid_i after grant does not cancel the access; it completes normally.
  - A requester re-asserting immediately after completion has lowest priority in the next arbitration.
- Simultaneous requests: strict round-robin; no requester waits more than NUM_REQ-1 grants.
- ready_i while in IDLE is ignored.
- rr_ptr wraps from NUM_REQ-1 to 0.
- timer width is $clog2(TIMEOUT)+1; it never wraps, because abort happens first.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, ISSUE), a function computing the round-robin winner index from a req vector and pointer, and the default TIMEOUT constant.
- One sub-module, rr_arbiter: request vector + pointer in, winner index + any_req out. Purely combinational, unit-testable alone.
- The top holds the FSM, the latches, the watchdog, and response routing.

Test Plan (NUM_REQ=4, WIDTH=32, ADDR_WIDTH=8, TIMEOUT=16):
- Single write: req0 writes addr 0x10, data 0xDEADBEEF; memory ready_i 2 cycles after valid_o. Required: valid_o/addr_o=0x10/wdata_o held for 3 cycles, exactly one req_ready_o[0] pulse, busy_o low afterwards.
- Read return: req2 reads 0x3F; memory returns rdata 0x12345678 with ready_i. Required: req_rdata_o=0x12345678 coincident with req_ready_o[2]=1; req_rdata_o=0 otherwise.
- Fairness: req0..3 all held high for 8 transactions, zero-wait memory. Required: grant order 0,1,2,3,0,1,2,3, each req_ready_o pulse spaced 2 cycles apart.
- Timeout: req1 reads, ready_i never asserted. Required: req_err_o[1] pulses in the 16th ISSUE cycle, valid_o drops next cycle, rr_ptr=2, no req_ready_o pulse.
- Reset mid-transaction: rst_i asserted in the 3rd ISSUE cycle. Required: next cycle all outputs 0, state IDLE, rr_ptr=0, no pulses. A subsequent request from req3 is granted normally.
- Early drop: req0 deasserts req_valid_i the cycle after grant. Required: access completes with the original addr/data and req_ready_o[0] still pulses.
